wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the main pipeline writeback (ALU result or memory data) and a multi-cycle unit (mult/div) that produces results late.
- Keeps a per-register busy scoreboard for destinations with a multi-cycle write still pending, and raises a decode stall when rs/rt hits a busy register.
- Prevents multi-cycle starvation by requesting a one-cycle pipeline hold.
- Sits between the writeback stage, the multi-cycle unit and the decode stage's register file.

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_port_arbiter_if.sv | 54 +++++
 rtl/wb_port_arbiter_scoreboard.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
//   Shared constants and types for the register-file write-port arbiter:
//   default data/address widths, register count, starvation counter width
//   and the hold FSM state encoding.
package wb_port_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
    localparam int STARVE_W   = 4;

    typedef enum logic {
        ARB_RUN  = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles every bus signal around the write-port arbiter.
//   master : the requesters (pipeline writeback, multi-cycle unit, decode)
//   slave  : the arbiter itself
//   Signals: pipe_we/pipe_waddr/pipe_wdata/pipe_hold (pipeline writeback),
//            mc_issue/mc_issue_rd (multi-cycle issue), mc_valid/mc_waddr/
//            mc_wdata/mc_ready (multi-cycle result handshake),
//            dec_rs/dec_rt/dec_stall (decode hazard check),
//            rf_we/rf_waddr/rf_wdata (register-file write port), err.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_hold;

    logic              mc_issue;
    logic [ADDR_W-1:0] mc_issue_rd;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_waddr;
    logic [DATA_W-1:0] mc_wdata;
    logic              mc_ready;

    logic [ADDR_W-1:0] dec_rs;
    logic [ADDR_W-1:0] dec_rt;
    logic              dec_stall;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              err;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output mc_issue, mc_issue_rd, mc_valid, mc_waddr, mc_wdata,
        output dec_rs, dec_rt,
        input  pipe_hold, mc_ready, dec_stall,
        input  rf_we, rf_waddr, rf_wdata, err
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  mc_issue, mc_issue_rd, mc_valid, mc_waddr, mc_wdata,
        input  dec_rs, dec_rt,
        output pipe_hold, mc_ready, dec_stall,
        output rf_we, rf_waddr, rf_wdata, err
    );

endinterface

// File: rtl/wb_port_arbiter_scoreboard.sv
// wb_scoreboard
//   Busy-bit vector for registers with a multi-cycle write still pending.
//   Ports: clock, reset (sync, active-low); set_en/set_addr mark a register
//   busy on issue; clr_en/clr_addr free it when the result transfers;
//   rd_addr_a/rd_addr_b -> busy_a/busy_b for the decode stall;
//   dbl_issue flags an issue to a register that is still busy.
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              dbl_issue
);

    localparam int NREGS = num_regs(ADDR_W);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a same-cycle issue to the register whose
    // result is retiring leaves it busy; register 0 can never be busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_a = busy_q[rd_addr_a];
    assign busy_b = busy_q[rd_addr_b];

    // Re-issuing to the register that is retiring this very cycle is legal.
    assign dbl_issue = set_en && (set_addr != '0) && busy_q[set_addr]
                       && !(clr_en && (clr_addr == set_addr));

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the pipeline
//   writeback and a multi-cycle unit. The pipeline always wins; a losing
//   multi-cycle result is protected from starvation by a one-cycle
//   pipe_hold. A busy scoreboard stalls decode on pending destinations.
//   Ports: clock, reset (sync, active-low), bus (wb_port_arbiter_if.slave).
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic                mc_ready;
    logic                mc_xfer;
    logic                mc_lose;
    logic                hold_active;
    logic                hold_violation;
    logic                win_valid;
    logic                win_write;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                rf_we_q;
    logic [ADDR_W-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic                err_q;
    logic                busy_rs;
    logic                busy_rt;
    logic                dbl_issue;

    assign mc_ready  = bus.mc_valid & ~bus.pipe_we;
    assign mc_xfer   = bus.mc_valid & mc_ready;
    assign mc_lose   = bus.mc_valid & ~mc_ready;
    assign win_valid = bus.pipe_we | mc_xfer;
    assign win_addr  = bus.pipe_we ? bus.pipe_waddr : bus.mc_waddr;
    assign win_data  = bus.pipe_we ? bus.pipe_wdata : bus.mc_wdata;
    // A write to register 0 completes its handshake but never reaches the file.
    assign win_write = win_valid && (win_addr != '0);

    assign hold_violation = hold_active & bus.pipe_we;

    always_ff @(posedge clock) begin
        if (!reset) state_q <= ARB_RUN;
        else        state_q <= state_d;
    end

    // Hold follows the cycle in which a saturated request is still losing,
    // or a hold cycle the pipeline ignored (the request lost again).
    always_comb begin
        state_d = ARB_RUN;
        if (hold_violation || (mc_lose && (starve_cnt == STARVE_MAX)))
            state_d = ARB_HOLD;
    end

    always_comb begin
        hold_active = (state_q == ARB_HOLD);
    end

    // Counts consecutive lost cycles and saturates at the hold threshold.
    always_ff @(posedge clock) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!bus.mc_valid || mc_xfer)
            starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Address/data keep their last value whenever nothing is written.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= win_write;
            if (win_write) begin
                rf_waddr_q <= win_addr;
                rf_wdata_q <= win_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            err_q <= 1'b0;
        else if (hold_violation || dbl_issue)
            err_q <= 1'b1;
    end

    wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (bus.mc_issue),
        .set_addr  (bus.mc_issue_rd),
        .clr_en    (mc_xfer),
        .clr_addr  (bus.mc_waddr),
        .rd_addr_a (bus.dec_rs),
        .rd_addr_b (bus.dec_rt),
        .busy_a    (busy_rs),
        .busy_b    (busy_rt),
        .dbl_issue (dbl_issue)
    );

    assign bus.mc_ready  = mc_ready;
    assign bus.pipe_hold = hold_active;
    assign bus.dec_stall = busy_rs | busy_rt;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Table-driven bench for wb_port_arbiter: each vector drives one cycle,
//   checks the combinational outputs before the edge and pushes the expected
//   register-file write into a queue that is popped after the edge.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    typedef struct {
        logic          pwe;
        logic [AW-1:0] pwa;
        logic [DW-1:0] pwd;
        logic          mv;
        logic [AW-1:0] mwa;
        logic [DW-1:0] mwd;
        logic          iss;
        logic [AW-1:0] ird;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          x_ready;
        logic          x_stall;
        logic          x_hold;
        logic          x_err;
    } vec_t;

    typedef struct {
        logic          we;
        logic          chk_ad;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rf_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rf_exp_t       exp_q[$];
    logic [AW-1:0] model_addr;
    logic [DW-1:0] model_data;
    vec_t          main_tbl[27];
    vec_t          viol_tbl[7];
    vec_t          zero_v;
    vec_t          rs7_v;

    always #5 clock = ~clock;

    wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic vec_t mk(
        input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
        input logic mv,  input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
        input logic iss, input logic [AW-1:0] ird,
        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
        input logic xr, input logic xs, input logic xh, input logic xe);
        vec_t v;
        v.pwe = pwe; v.pwa = pwa; v.pwd = pwd;
        v.mv  = mv;  v.mwa = mwa; v.mwd = mwd;
        v.iss = iss; v.ird = ird; v.rs = rs; v.rt = rt;
        v.x_ready = xr; v.x_stall = xs; v.x_hold = xh; v.x_err = xe;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        bus.pipe_we     = v.pwe;
        bus.pipe_waddr  = v.pwa;
        bus.pipe_wdata  = v.pwd;
        bus.mc_valid    = v.mv;
        bus.mc_waddr    = v.mwa;
        bus.mc_wdata    = v.mwd;
        bus.mc_issue    = v.iss;
        bus.mc_issue_rd = v.ird;
        bus.dec_rs      = v.rs;
        bus.dec_rt      = v.rt;
    endtask

    // Drives the vector and predicts the register-file write it should cause.
    task automatic applyStimulus(input vec_t v);
        rf_exp_t e;
        driveInputs(v);
        if (v.pwe) begin
            e.we = (v.pwa != '0); e.chk_ad = e.we; e.addr = v.pwa; e.data = v.pwd;
        end else if (v.mv) begin
            e.we = (v.mwa != '0); e.chk_ad = e.we; e.addr = v.mwa; e.data = v.mwd;
        end else begin
            e.we = 1'b0; e.chk_ad = 1'b1; e.addr = model_addr; e.data = model_data;
        end
        if (e.we) begin
            model_addr = e.addr;
            model_data = e.data;
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        checkOutput({tag, ".mc_ready"},  32'(bus.mc_ready),  32'(v.x_ready));
        checkOutput({tag, ".dec_stall"}, 32'(bus.dec_stall), 32'(v.x_stall));
        checkOutput({tag, ".pipe_hold"}, 32'(bus.pipe_hold), 32'(v.x_hold));
        checkOutput({tag, ".err"},       32'(bus.err),       32'(v.x_err));
    endtask

    task automatic clockAndCompare(input string tag);
        rf_exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.queue actual=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, ".rf_we"}, 32'(bus.rf_we), 32'(e.we));
            if (e.chk_ad) begin
                checkOutput({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(e.addr));
                checkOutput({tag, ".rf_wdata"}, bus.rf_wdata, e.data);
            end
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        checkVector(v, tag);
        clockAndCompare(tag);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".rf_we"},     32'(bus.rf_we),     32'd0);
        checkOutput({tag, ".rf_waddr"},  32'(bus.rf_waddr),  32'd0);
        checkOutput({tag, ".rf_wdata"},  bus.rf_wdata,       32'd0);
        checkOutput({tag, ".pipe_hold"}, 32'(bus.pipe_hold), 32'd0);
        checkOutput({tag, ".err"},       32'(bus.err),       32'd0);
        checkOutput({tag, ".dec_stall"}, 32'(bus.dec_stall), 32'd0);
        checkOutput({tag, ".mc_ready"},  32'(bus.mc_ready),  32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // pwe pwa pwd | mv mwa mwd | iss ird | rs rt | ready stall hold err
        main_tbl[0]  = mk(1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[1]  = mk(1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[2]  = mk(1'b1, 5'd4,  32'h44444444, 1'b1, 5'd9,  32'h99999999, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[3]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99999999, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        main_tbl[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[5]  = mk(1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[6]  = mk(1'b1, 5'd11, 32'h0B0B0B0B, 1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[7]  = mk(1'b1, 5'd13, 32'h0D0D0D0D, 1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[8]  = mk(1'b1, 5'd14, 32'h0E0E0E0E, 1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[9]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0);
        main_tbl[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[12] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0);
        main_tbl[13] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        main_tbl[14] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0FFEE00, 1'b0, 5'd0,  5'd12, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0);
        main_tbl[15] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[16] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[17] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h55555555, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0);
        main_tbl[18] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0);
        main_tbl[19] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h5A5A5A5A, 1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0);
        main_tbl[20] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[21] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        main_tbl[22] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd12, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0);
        main_tbl[23] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1);
        main_tbl[24] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h1212ABCD, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1);
        main_tbl[25] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd12, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        main_tbl[26] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1);

        viol_tbl[0] = mk(1'b1, 5'd21, 32'h15151515, 1'b1, 5'd25, 32'h19191919, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        viol_tbl[1] = mk(1'b1, 5'd22, 32'h16161616, 1'b1, 5'd25, 32'h19191919, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        viol_tbl[2] = mk(1'b1, 5'd23, 32'h17171717, 1'b1, 5'd25, 32'h19191919, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        viol_tbl[3] = mk(1'b1, 5'd24, 32'h18181818, 1'b1, 5'd25, 32'h19191919, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        viol_tbl[4] = mk(1'b1, 5'd26, 32'h1A1A1A1A, 1'b1, 5'd25, 32'h19191919, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        viol_tbl[5] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd25, 32'h19191919, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        viol_tbl[6] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        zero_v = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rs7_v  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] power-on reset");
        reset = 1'b0;
        driveInputs(zero_v);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1 checkReset("por");
        model_addr = '0;
        model_data = '0;

        $display("[TB] main vector table");
        for (int i = 0; i < 27; i++)
            runVector(main_tbl[i], $sformatf("main%0d", i));

        $display("[TB] reset mid-operation");
        runVector(mk(1'b1, 5'd8, 32'h88888888, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0,
                     1'b0, 1'b0, 1'b0, 1'b1), "midA");
        runVector(mk(1'b1, 5'd8, 32'h88880001, 1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 5'd7, 5'd0,
                     1'b0, 1'b1, 1'b0, 1'b1), "midB");
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        driveInputs(rs7_v);
        #1 checkReset("midrst");
        exp_q.delete();
        model_addr = '0;
        model_data = '0;

        $display("[TB] starvation hold violation");
        for (int i = 0; i < 7; i++)
            runVector(viol_tbl[i], $sformatf("viol%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
